// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - IFU/LSU arbiter for the data RAM with read-modify-write for partial stores
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        ram_we_o,
    output logic [31:0] ram_waddr_o,
    output logic [31:0] ram_wdata_o,
    output logic [31:0] ram_raddr_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_RMW_MERGE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ifu_own_q, ifu_own_d;
    logic             lsu_own_q, lsu_own_d;
    logic [31:0]      raddr_q, raddr_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ifu_gnt, lsu_gnt, ram_we;
    logic             ifu_win, lsu_win;
    logic [31:0]      ifu_map, lsu_map, merged;
    logic             unused_addr_bits;

    // Bit 31 and the byte offset never reach the RAM.
    assign ifu_map = {1'b0, ifu_addr_i[30:2], 2'b00};
    assign lsu_map = {1'b0, lsu_addr_i[30:2], 2'b00};
    assign unused_addr_bits = ^{ifu_addr_i[31], ifu_addr_i[1:0], lsu_addr_i[31], lsu_addr_i[1:0]};

    assign ifu_win = ifu_req_i && (!lsu_req_i || (cnt_q >= CNT_W'(STARVE_LIMIT)));
    assign lsu_win = lsu_req_i && !ifu_win;

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lsu_be_i[i] ? lsu_wdata_i[8*i +: 8] : ram_rdata_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ifu_own_d = 1'b0;
        lsu_own_d = 1'b0;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ifu_gnt   = 1'b0;
        lsu_gnt   = 1'b0;
        ram_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ifu_win) begin
                    raddr_d   = ifu_map;
                    ifu_gnt   = 1'b1;
                    ifu_own_d = 1'b1;
                    cnt_d     = '0;
                end else if (lsu_win) begin
                    if (ifu_req_i && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!lsu_we_i) begin
                        raddr_d   = lsu_map;
                        lsu_gnt   = 1'b1;
                        lsu_own_d = 1'b1;
                    end else if (lsu_be_i == 4'hF) begin
                        ram_we  = 1'b1;
                        waddr_d = lsu_map;
                        wdata_d = lsu_wdata_i;
                        lsu_gnt = 1'b1;
                    end else if (lsu_be_i == 4'h0) begin
                        lsu_gnt = 1'b1;
                    end else begin
                        raddr_d = lsu_map;
                        state_d = S_RMW_MERGE;
                    end
                end
            end
            default: begin
                // Requester holds addr/be/wdata, so the merge uses the live inputs.
                ram_we  = 1'b1;
                waddr_d = lsu_map;
                wdata_d = merged;
                lsu_gnt = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            ifu_gnt = 1'b0;
            lsu_gnt = 1'b0;
            ram_we  = 1'b0;
            raddr_d = '0;
            waddr_d = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ifu_own_q <= 1'b0;
            lsu_own_q <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ifu_own_q <= ifu_own_d;
            lsu_own_q <= lsu_own_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign ifu_gnt_o    = ifu_gnt;
    assign lsu_gnt_o    = lsu_gnt;
    assign ram_we_o     = ram_we;
    assign ram_raddr_o  = raddr_d;
    assign ram_waddr_o  = waddr_d;
    assign ram_wdata_o  = wdata_d;
    assign ifu_rvalid_o = ifu_own_q && !rst;
    assign lsu_rvalid_o = lsu_own_q && !rst;
    assign ifu_rdata_o  = ifu_rvalid_o ? ram_rdata_i : '0;
    assign lsu_rdata_o  = lsu_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        ifu_req, ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        ram_we;
    logic [31:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt),
        .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hA000_00A0;
            mem[1] <= 32'hA100_00A1;
            mem[2] <= 32'hA200_00A2;
            mem[8] <= 32'h1122_3344;
        end else if (ram_we) begin
            mem[ram_waddr[9:2]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_req = 1'b0; ifu_addr = 32'h0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
    endtask

    task automatic lsu_drive(input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req = 1'b1; lsu_we = we; lsu_be = be; lsu_addr = addr; lsu_wdata = wdata;
    endtask

    initial begin
        logic [31:0] ifu_seq [0:2];
        logic [31:0] ifu_exp [0:2];
        ifu_seq[0] = 32'h0; ifu_seq[1] = 32'h4; ifu_seq[2] = 32'h8;
        ifu_exp[0] = 32'hA000_00A0; ifu_exp[1] = 32'hA100_00A1; ifu_exp[2] = 32'hA200_00A2;

        rst = 1'b1; preload = 1'b1;
        idle_inputs();
        next_cycle();
        preload = 1'b0;
        next_cycle();

        // Request during reset: no grant, outputs zero, no rvalid afterwards
        ifu_req = 1'b1; ifu_addr = 32'h8;
        sample();
        check("rst_ifu_gnt", 32'(ifu_gnt), 32'h0);
        check("rst_raddr", ram_raddr, 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        next_cycle();
        rst = 1'b0; ifu_req = 1'b0;
        sample();
        check("post_rst_rvalid", 32'(ifu_rvalid), 32'h0);
        check("post_rst_lsu_rvalid", 32'(lsu_rvalid), 32'h0);

        // Back-to-back IFU reads
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i < 3) begin
                ifu_req = 1'b1; ifu_addr = ifu_seq[i];
            end else begin
                ifu_req = 1'b0;
            end
            sample();
            check("ifu_gnt", 32'(ifu_gnt), (i < 3) ? 32'h1 : 32'h0);
            if (i < 3) check("ifu_raddr", ram_raddr, ifu_seq[i]);
            check("ifu_rvalid", 32'(ifu_rvalid), (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) check("ifu_rdata", ifu_rdata, ifu_exp[i-1]);
        end

        // Full-word store then load
        next_cycle();
        idle_inputs();
        lsu_drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        sample();
        check("st_gnt", 32'(lsu_gnt), 32'h1);
        check("st_we", 32'(ram_we), 32'h1);
        check("st_waddr", ram_waddr, 32'h10);
        check("st_wdata", ram_wdata, 32'hDEAD_BEEF);
        next_cycle();
        lsu_drive(1'b0, 4'hF, 32'h10, 32'h0);
        sample();
        check("ld_gnt", 32'(lsu_gnt), 32'h1);
        check("ld_we", 32'(ram_we), 32'h0);
        check("ld_raddr", ram_raddr, 32'h10);
        check("st_no_rvalid", 32'(lsu_rvalid), 32'h0);
        next_cycle();
        idle_inputs();
        sample();
        check("ld_rvalid", 32'(lsu_rvalid), 32'h1);
        check("ld_rdata", lsu_rdata, 32'hDEAD_BEEF);
        check("ld_ifu_rvalid", 32'(ifu_rvalid), 32'h0);

        // be=0 store: grant, no RAM write
        next_cycle();
        lsu_drive(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
        sample();
        check("be0_gnt", 32'(lsu_gnt), 32'h1);
        check("be0_we", 32'(ram_we), 32'h0);

        // Partial store RMW
        next_cycle();
        lsu_drive(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        sample();
        check("rmw1_gnt", 32'(lsu_gnt), 32'h0);
        check("rmw1_we", 32'(ram_we), 32'h0);
        check("rmw1_raddr", ram_raddr, 32'h20);
        next_cycle();
        sample();
        check("rmw2_gnt", 32'(lsu_gnt), 32'h1);
        check("rmw2_we", 32'(ram_we), 32'h1);
        check("rmw2_waddr", ram_waddr, 32'h20);
        check("rmw2_wdata", ram_wdata, 32'h11BB_33DD);
        check("rmw2_rvalid", 32'(lsu_rvalid), 32'h0);
        next_cycle();
        idle_inputs();
        sample();
        check("rmw_done_we", 32'(ram_we), 32'h0);
        check("rmw_done_rvalid", 32'(lsu_rvalid), 32'h0);

        // Address aliasing
        next_cycle();
        ifu_req = 1'b1; ifu_addr = 32'h8000_0006;
        sample();
        check("alias_gnt", 32'(ifu_gnt), 32'h1);
        check("alias_raddr", ram_raddr, 32'h0000_0004);
        next_cycle();
        ifu_req = 1'b0;
        sample();
        check("alias_rdata", ifu_rdata, 32'hA100_00A1);

        // Starvation: both requesting, LSU x4 then IFU x1
        next_cycle();
        ifu_req = 1'b1; ifu_addr = 32'h4;
        lsu_drive(1'b0, 4'hF, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            sample();
            check($sformatf("starve_ifu_%0d", k), 32'(ifu_gnt), (k % 5 == 4) ? 32'h1 : 32'h0);
            check($sformatf("starve_lsu_%0d", k), 32'(lsu_gnt), (k % 5 == 4) ? 32'h0 : 32'h1);
            next_cycle();
        end
        idle_inputs();

        // Reset during RMW_MERGE, then the re-request completes
        next_cycle();
        lsu_drive(1'b1, 4'b0011, 32'h20, 32'h5566_7788);
        sample();
        check("rrmw1_gnt", 32'(lsu_gnt), 32'h0);
        next_cycle();
        rst = 1'b1;
        sample();
        check("rrmw_we", 32'(ram_we), 32'h0);
        check("rrmw_gnt", 32'(lsu_gnt), 32'h0);
        check("rrmw_waddr", ram_waddr, 32'h0);
        check("rrmw_wdata", ram_wdata, 32'h0);
        check("rrmw_raddr", ram_raddr, 32'h0);
        next_cycle();
        rst = 1'b0;
        sample();
        check("rrmw_again1_gnt", 32'(lsu_gnt), 32'h0);
        check("rrmw_again1_raddr", ram_raddr, 32'h20);
        next_cycle();
        sample();
        check("rrmw_again2_gnt", 32'(lsu_gnt), 32'h1);
        check("rrmw_again2_wdata", ram_wdata, 32'h11BB_7788);
        next_cycle();
        lsu_drive(1'b0, 4'hF, 32'h20, 32'h0);
        sample();
        check("final_ld_gnt", 32'(lsu_gnt), 32'h1);
        next_cycle();
        idle_inputs();
        sample();
        check("final_ld_rdata", lsu_rdata, 32'h11BB_7788);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port-per-direction data RAM between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte enables).
- Sits between the core and the RAM peripheral.
- Serialises accesses and steers read data back to its owner.
- Performs read-modify-write for partial stores, because the RAM only writes full words.

Parameters:
- STARVE_LIMIT, 4: consecutive IFU losses after which the IFU is granted ahead of the LSU.
- CNT_W, 3: starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_i  in  1  fetch request, held until granted
- ifu_addr_i  in  32  fetch byte address
- ifu_gnt_o  out  1  fetch accepted (one-cycle pulse)
- ifu_rvalid_o  out  1  fetch data valid
- ifu_rdata_o  out  32  fetch data
- lsu_req_i  in  1  LSU request, held until granted
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_be_i  in  4  store byte enables (bit n = byte n)
- lsu_addr_i  in  32  LSU byte address
- lsu_wdata_i  in  32  store data
- lsu_gnt_o  out  1  LSU accepted (one-cycle pulse)
- lsu_rvalid_o  out  1  load data valid
- lsu_rdata_o  out  32  load data
- ram_we_o  out  1  RAM write enable
- ram_waddr_o  out  32  RAM write address
- ram_wdata_o  out  32  RAM write data
- ram_raddr_o  out  32  RAM read address
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_raddr_o is presented

Behaviour:
- Clock and reset: clk is the clock; rst is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - State IDLE, starvation counter 0, owner flags cleared.
  - A read granted in the reset cycle produces no rvalid.
  - Reset during RMW_MERGE abandons the store: no write, no grant.
- Address mapping: RAM addresses are {1'b0, addr[30:2], 2'b00}. Bits 31 and [1:0] are ignored; misalignment is not checked.
- Handshake:
  - Requester holds req, addr, we, be and wdata stable until gnt.
  - gnt is combinational, pulses in the accepting cycle, and is forced 0 while rst is high.
  - At most one grant per cycle.
- States: IDLE, RMW_MERGE.
- IDLE arbitration:
  - Default: LSU wins if lsu_req_i is high.
  - Override: IFU wins if the counter is at or above STARVE_LIMIT and ifu_req_i is high.
  - Counter increments, saturating, when the IFU requests and loses; clears on any IFU grant.
- IDLE actions for the winner:
  - Read (IFU, or LSU with we=0): ram_raddr_o = mapped address, gnt=1. Set the owner flag so that next cycle the owner's rvalid=1 and rdata = ram_rdata_i. Back-to-back reads issue every cycle, giving 1-cycle latency and full throughput.
  - LSU store with be=4'hF: ram_we_o=1, ram_waddr_o = mapped address, ram_wdata_o = wdata, lsu_gnt_o=1 in the same cycle. No rvalid.
  - LSU store with be=4'h0: lsu_gnt_o=1, no RAM access.
  - LSU partial store (be neither 0 nor F):
    - Cycle N: ram_raddr_o = mapped address, no grant, go to RMW_MERGE.
    - Cycle N+1: merge byte n = be[n] ? wdata byte n : ram_rdata_i byte n. Drive ram_we_o=1 with the merged word, pulse lsu_gnt_o, return to IDLE.
    - No rvalid for the store.
- RMW_MERGE:
  - No other grants.
  - An rvalid owed from cycle N-1 is still delivered this cycle; the RAM read port is independent.
- Ordering:
  - A write is visible to any read issued in the cycle after the write.
  - The arbiter never reads and writes in the same cycle, except the RMW merge cycle, which issues no read.
- Idle outputs: ram_we_o=0; addresses and data hold their last value (don't-care).

Test Plan:
- IFU-only reads: IFU reads addresses 0x0, 0x4, 0x8 on consecutive cycles -> gnt every cycle; ifu_rvalid_o on cycles 1-3 with preloaded words in order.
- Full-word store then load: LSU stores 0xDEADBEEF to 0x10 with be=F -> ram_we_o pulses once with waddr 0x10; the following load of 0x10 returns 0xDEADBEEF after 1 cycle on lsu_rdata_o.
- Partial store: word 0x11223344 at 0x20; LSU stores 0xAABBCCDD with be=4'b0101 -> RMW takes 2 cycles, gnt only in cycle 2, RAM word becomes 0x11BB33DD.
- Starvation: both request continuously, STARVE_LIMIT=4 -> LSU granted 4 times, then IFU once, repeating; no requester idle more than 5 cycles.
- Address aliasing: IFU reads 0x80000006 -> ram_raddr_o = 0x00000004.
- Reset mid-RMW: rst asserted in the RMW_MERGE cycle -> no ram_we_o, no lsu_gnt_o, all outputs 0; the LSU re-request after reset completes normally.
